// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg -- shared constants and types for the mips_mem memory block.
//   state_t  : FSM state encoding (IDLE, BUSY, RESP)
//   WAIT_MAX : largest supported wait-state count
//   CNT_W    : wait counter width, wide enough for WAIT_MAX
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/mips_mem_array.sv
// mips_mem_array -- byte-lane writable synchronous RAM, no reset on contents.
//   clk   : clock
//   en    : perform an access at this edge
//   we    : 1 = write lanes selected by be, 0 = read into q
//   be    : byte-lane enables, bit i covers wdata[8i+7:8i]
//   idx   : word index (caller guarantees idx < DEPTH)
//   wdata : write data
//   q     : registered read data, updated only on read accesses
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                q <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mips_mem.sv
// mips_mem -- single-port wait-state memory with req/ready/ack handshake.
// Handshake: a request is accepted on a rising edge where ready=1 and req=1;
// inputs are ignored while ready=0. Every accepted request produces exactly
// one ack pulse WAIT_CYC+1 cycles after the accept edge; err and (for reads)
// rdata are valid while ack=1.
//   clk, rst  : clock, synchronous active-high reset
//   req, we   : request strobe, write(1)/read(0)
//   be        : byte-lane write enables
//   addr      : word address
//   wdata     : write data
//   ready     : request can be accepted this cycle (IDLE)
//   ack       : one-cycle completion pulse (RESP)
//   err       : access was out of range (addr >= DEPTH)
//   rdata     : read data; holds last read value between acks
//   state_dbg : current FSM state for observation
// Optional build macro: MIPS_MEM_TRISTATE_EN -- rdata is high-Z whenever ack=0.
module mips_mem
    import mips_mem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                ready,
    output logic                ack,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output state_t              state_dbg
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  lat_we;
    logic [DATA_W/8-1:0]   lat_be;
    logic [IDX_W-1:0]      lat_idx;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  lat_oob;
    logic [DATA_W-1:0]     rdata_hold;
    logic [DATA_W-1:0]     mem_q;
    logic [DATA_W-1:0]     rd_val;
    logic [DATA_W-1:0]     rdata_int;
    logic                  addr_oob;
    logic                  access;

    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    assign addr_oob = ({1'b0, addr} >= (ADDR_W+1)'(DEPTH));

    // Array access happens on the last BUSY edge; a reset on that same edge
    // aborts it, so nothing is written.
    assign access = (state == BUSY) && (cnt == '0) && !rst;

    mips_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (access && !lat_oob),
        .we    (lat_we),
        .be    (lat_be),
        .idx   (lat_idx),
        .wdata (lat_wdata),
        .q     (mem_q)
    );

    assign rd_val = lat_oob ? '0 : mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ready      <= 1'b1;
            ack        <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_be    <= be;
                        lat_idx   <= addr[IDX_W-1:0];
                        lat_wdata <= wdata;
                        lat_oob   <= addr_oob;
                        cnt       <= CNT_W'(WAIT_CYC);
                        ready     <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ack   <= 1'b1;
                        err   <= lat_oob;
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Capture the read value so rdata keeps it after ack.
                    if (!lat_we) rdata_hold <= rd_val;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // During a read ack show the fresh array word; otherwise the held value.
    assign rdata_int = (ack && !lat_we) ? rd_val : rdata_hold;

`ifdef MIPS_MEM_TRISTATE_EN
    assign rdata = ack ? rdata_int : {DATA_W{1'bz}};
`else
    assign rdata = rdata_int;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_mips_mem.sv
// tb_mips_mem -- directed self-checking bench for mips_mem
// (DATA_W=16, ADDR_W=20, DEPTH=1024, WAIT_CYC=1, default build).
module tb_mips_mem;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  be  = 2'b00;
    logic [19:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        ready;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    state_t      state_dbg;

    int tests = 0;
    int fails = 0;

    // clock / reset block
    always #5 clk = ~clk;

    mips_mem #(
        .DATA_W   (16),
        .ADDR_W   (20),
        .DEPTH    (1024),
        .WAIT_CYC (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its ack; returns latency in edges
    // after the accept edge (0 if no ack within the budget).
    task automatic access(input logic w, input logic [1:0] b, input logic [19:0] a,
                          input logic [15:0] d, output logic [15:0] rd,
                          output logic e, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!ready) check("ready_wait", 32'(ready), 32'd1);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0;
        lat = 0; rd = 'x; e = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            if (ack) begin
                lat = n - 1;
                rd  = rdata;
                e   = err;
                break;
            end
            tick();
        end
        if (lat == 0 && !ack) check("ack_timeout", 32'(ack), 32'd1);
    endtask

    logic [15:0] rd;
    logic        e;
    int          lat;
    int          ack_cnt;

    initial begin
        // reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", 32'(rdata), 32'h0000);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // write then read address 0
        access(1'b1, 2'b11, 20'd0, 16'h000F, rd, e, lat);
        check("w0_lat", 32'(lat), 32'd2);
        check("w0_err", 32'(e),   32'd0);
        tick();
        check("ack_one_cycle", 32'(ack), 32'd0);
        access(1'b0, 2'b00, 20'd0, 16'h0000, rd, e, lat);
        check("r0_lat",   32'(lat), 32'd2);
        check("r0_rdata", 32'(rd),  32'h000F);
        check("r0_err",   32'(e),   32'd0);
        tick();
        check("r0_hold", 32'(rdata), 32'h000F);

        // byte lanes on address 5
        access(1'b1, 2'b11, 20'd5, 16'h1234, rd, e, lat);
        access(1'b1, 2'b10, 20'd5, 16'hABCD, rd, e, lat);
        check("w5_hi_hold_rdata", 32'(rdata), 32'h000F);
        access(1'b0, 2'b00, 20'd5, 16'h0000, rd, e, lat);
        check("r5_lanes", 32'(rd), 32'hAB34);
        access(1'b1, 2'b00, 20'd5, 16'hFFFF, rd, e, lat);
        check("w5_be0_lat", 32'(lat), 32'd2);
        access(1'b0, 2'b00, 20'd5, 16'h0000, rd, e, lat);
        check("r5_be0_noop", 32'(rd), 32'hAB34);
        access(1'b1, 2'b01, 20'd5, 16'h00EE, rd, e, lat);
        access(1'b0, 2'b00, 20'd5, 16'h0000, rd, e, lat);
        check("r5_lo_lane", 32'(rd), 32'hABEE);

        // top in-range address
        access(1'b1, 2'b11, 20'd1023, 16'hBEEF, rd, e, lat);
        check("w1023_err", 32'(e), 32'd0);
        access(1'b0, 2'b00, 20'd1023, 16'h0000, rd, e, lat);
        check("r1023_rdata", 32'(rd), 32'hBEEF);
        check("r1023_err",   32'(e),  32'd0);

        // out of range
        access(1'b1, 2'b11, 20'd1024, 16'hFFFF, rd, e, lat);
        check("w1024_lat", 32'(lat), 32'd2);
        check("w1024_err", 32'(e),   32'd1);
        access(1'b0, 2'b00, 20'd1024, 16'h0000, rd, e, lat);
        check("r1024_rdata", 32'(rd), 32'h0000);
        check("r1024_err",   32'(e),  32'd1);
        access(1'b0, 2'b00, 20'd0, 16'h0000, rd, e, lat);
        check("r0_after_oob", 32'(rd), 32'h000F);

        // reset one cycle after accept aborts the write
        access(1'b1, 2'b11, 20'd3, 16'h1111, rd, e, lat);
        tick();
        req = 1'b1; we = 1'b1; be = 2'b11; addr = 20'd3; wdata = 16'h5555;
        tick();
        req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort1_ready", 32'(ready), 32'd1);
        check("abort1_rdata", 32'(rdata), 32'h0000);
        check("abort1_state", 32'(state_dbg), 32'(IDLE));
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack) ack_cnt++;
            tick();
        end
        check("abort1_no_ack", 32'(ack_cnt), 32'd0);
        access(1'b0, 2'b00, 20'd3, 16'h0000, rd, e, lat);
        check("abort1_r3", 32'(rd), 32'h1111);

        // reset on the access edge itself also aborts
        tick();
        req = 1'b1; we = 1'b1; be = 2'b11; addr = 20'd3; wdata = 16'h7777;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort2_ack", 32'(ack), 32'd0);
        access(1'b0, 2'b00, 20'd3, 16'h0000, rd, e, lat);
        check("abort2_r3", 32'(rd), 32'h1111);

        // req held high for 8 cycles: exactly 2 reads accepted
        tick();
        req = 1'b1; we = 1'b0; be = 2'b00; addr = 20'd0;
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) begin
                ack_cnt++;
                check("held_rdata", 32'(rdata), 32'h000F);
            end
        end
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack) ack_cnt++;
        end
        check("held_ack_count", 32'(ack_cnt), 32'd2);
        check("held_idle", 32'(ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
